// File: rtl/eth_rx_mac_filter_pkg.sv
// Shared Ethernet constants, receive-filter FSM encoding and the DA accept rule.
package eth_pkg;

  localparam int          ETH_MAC_LEN        = 6;
  localparam int          ETH_HDR_LEN        = 14;
  localparam int          ETH_MIN_LEN_NO_FCS = 60;
  localparam logic [47:0] ETH_BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DA,
    ST_PASS,
    ST_DROP,
    ST_FLUSH
  } rx_state_e;

  // Destination-address filter; bit 40 is the I/G bit of the first DA byte.
  function automatic logic mac_accept(
    input logic [47:0] da,
    input logic [47:0] stn_mac,
    input logic        promisc,
    input logic        bcast_en,
    input logic        mcast_en
  );
    logic is_bcast;
    is_bcast = (da == ETH_BCAST_MAC);
    return promisc | (da == stn_mac) | (is_bcast & bcast_en) |
           (da[40] & ~is_bcast & mcast_en);
  endfunction

endpackage

// File: rtl/eth_rx_mac_filter_if.sv
// Byte-wide AXI-Stream bundle without tready (the receiver never stalls).
interface eth_rx_mac_filter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, tvalid, tlast, tuser);
  modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/eth_rx_mac_filter_delay6.sv
// Six-byte delay line: holds the DA until the filter decides, then acts as
// the pipeline delay in PASS and drains its contents at end of frame.
module axis_byte_delay6
  import eth_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic [7:0]               dout_o,
  output logic [8*ETH_MAC_LEN-1:0] la_o,
  output logic                     empty_o,
  output logic                     last_o
);

  logic [ETH_MAC_LEN-1:0][7:0] mem_q;
  logic [2:0]                  cnt_q;

  // Slot 0 takes the newest byte; the oldest byte always sits in the top slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else if (push_i) begin
      mem_q <= {mem_q[ETH_MAC_LEN-2:0], din_i};
      if (cnt_q != 3'(ETH_MAC_LEN)) cnt_q <= cnt_q + 3'd1;
    end else if (pop_i) begin
      mem_q <= {mem_q[ETH_MAC_LEN-2:0], 8'h00};
      if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
    end
  end

  assign dout_o  = mem_q[ETH_MAC_LEN-1];
  // Five stored bytes plus the incoming one: the complete DA on the 6th beat.
  assign la_o    = {mem_q[ETH_MAC_LEN-2:0], din_i};
  assign empty_o = (cnt_q == 3'd0);
  assign last_o  = (cnt_q == 3'd1);

endmodule

// File: rtl/eth_rx_mac_filter.sv
// Receive DA filter: parses the Ethernet header, drops rejected frames whole,
// forwards accepted frames byte-exact and flags runt/oversize on tuser.
module eth_rx_mac_filter
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  eth_rx_mac_filter_if.slave   s_axis,
  eth_rx_mac_filter_if.master  m_axis,
  output logic                 m_eth_hdr_valid,
  output logic [47:0]          m_eth_dest_mac,
  output logic [47:0]          m_eth_src_mac,
  output logic [15:0]          m_eth_type,
  input  logic [47:0]          cfg_local_mac,
  input  logic                 cfg_promisc,
  input  logic                 cfg_bcast_enable,
  input  logic                 cfg_mcast_enable,
  input  logic [LEN_WIDTH-1:0] cfg_max_len,
  output logic                 stat_frame_accepted,
  output logic                 stat_frame_dropped,
  output logic                 stat_frame_runt,
  output logic                 stat_frame_oversize
);

  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("eth_rx_mac_filter: DATA_WIDTH must be 8");
  end

  rx_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 beat, last;
  logic [7:0]           din;

  logic                 dl_push, dl_pop, dl_clr, dl_empty, dl_last;
  logic [7:0]           dl_dout;
  logic [47:0]          dl_la;

  logic                 bad_q, bad_d, runt_q, runt_d, over_q, over_d;
  logic                 pend_q, pend_d, pend_done_q, pend_done_d;
  logic                 pend_now, done_now, len_runt, len_over;

  logic [7:0]           tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic                 st_acc_q, st_acc_d, st_drop_q, st_drop_d;
  logic                 st_runt_q, st_runt_d, st_over_q, st_over_d;

  logic                 hdr_vld_q;
  logic [47:0]          da_q, src_sh_q, dest_q, src_q;
  logic [7:0]           type_hi_q;
  logic [15:0]          type_q;

  assign beat     = s_axis.tvalid;
  assign last     = s_axis.tvalid & s_axis.tlast;
  assign din      = s_axis.tdata;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign len_runt = cnt_inc < LEN_WIDTH'(ETH_MIN_LEN_NO_FCS);
  assign len_over = cnt_inc > cfg_max_len;
  assign pend_now = pend_q | beat;
  assign done_now = pend_done_q | last;

  axis_byte_delay6 u_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (dl_clr),
    .push_i  (dl_push),
    .pop_i   (dl_pop),
    .din_i   (din),
    .dout_o  (dl_dout),
    .la_o    (dl_la),
    .empty_o (dl_empty),
    .last_o  (dl_last)
  );

  // Next state, delay-line control and the next value of every registered output.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dl_push     = 1'b0;
    dl_pop      = 1'b0;
    dl_clr      = 1'b0;
    bad_d       = bad_q;
    runt_d      = runt_q;
    over_d      = over_q;
    pend_d      = 1'b0;
    pend_done_d = 1'b0;
    tdata_d     = dl_dout;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    tuser_d     = 1'b0;
    st_acc_d    = 1'b0;
    st_drop_d   = 1'b0;
    st_runt_d   = 1'b0;
    st_over_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (beat) begin
          dl_push = 1'b1;
          cnt_d   = LEN_WIDTH'(1);
          if (last) begin
            // One-byte frame: too short to ever carry a DA.
            dl_clr    = 1'b1;
            st_drop_d = 1'b1;
            st_runt_d = 1'b1;
          end else begin
            state_d = ST_DA;
          end
        end
      end
      ST_DA: begin
        if (beat) begin
          dl_push = 1'b1;
          cnt_d   = cnt_inc;
          if (last) begin
            dl_clr    = 1'b1;
            st_drop_d = 1'b1;
            st_runt_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (cnt_q == LEN_WIDTH'(ETH_MAC_LEN - 1)) begin
            if (mac_accept(dl_la, cfg_local_mac, cfg_promisc,
                           cfg_bcast_enable, cfg_mcast_enable)) begin
              state_d = ST_PASS;
            end else begin
              dl_clr  = 1'b1;
              state_d = ST_DROP;
            end
          end
        end
      end
      ST_PASS: begin
        if (beat) begin
          dl_push  = 1'b1;
          cnt_d    = cnt_inc;
          tvalid_d = 1'b1;
          if (last) begin
            bad_d   = s_axis.tuser | len_runt | len_over;
            runt_d  = len_runt;
            over_d  = len_over;
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // Input keeps arriving here; remember it so that frame is dropped whole.
        pend_d      = pend_now;
        pend_done_d = done_now;
        dl_pop      = ~dl_empty;
        tvalid_d    = ~dl_empty;
        if (dl_last || dl_empty) begin
          tlast_d     = ~dl_empty;
          tuser_d     = bad_q & ~dl_empty;
          st_acc_d    = 1'b1;
          st_runt_d   = runt_q;
          st_over_d   = over_q;
          pend_d      = 1'b0;
          pend_done_d = 1'b0;
          if (done_now) begin
            st_drop_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (pend_now) begin
            state_d = ST_DROP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (last) begin
          st_drop_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, frame counter, end-of-frame flags and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bad_q       <= 1'b0;
      runt_q      <= 1'b0;
      over_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_done_q <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      st_acc_q    <= 1'b0;
      st_drop_q   <= 1'b0;
      st_runt_q   <= 1'b0;
      st_over_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bad_q       <= bad_d;
      runt_q      <= runt_d;
      over_q      <= over_d;
      pend_q      <= pend_d;
      pend_done_q <= pend_done_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      st_acc_q    <= st_acc_d;
      st_drop_q   <= st_drop_d;
      st_runt_q   <= st_runt_d;
      st_over_q   <= st_over_d;
    end
  end

  // Header capture: DA at the filter decision, SA/type from bytes 7..14,
  // all three published together the cycle after byte 14.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_vld_q <= 1'b0;
      da_q      <= '0;
      src_sh_q  <= '0;
      type_hi_q <= '0;
      dest_q    <= '0;
      src_q     <= '0;
      type_q    <= '0;
    end else begin
      hdr_vld_q <= 1'b0;
      if (state_q == ST_DA && beat && cnt_q == LEN_WIDTH'(ETH_MAC_LEN - 1))
        da_q <= dl_la;
      if (state_q == ST_PASS && beat) begin
        if (cnt_q >= LEN_WIDTH'(ETH_MAC_LEN) && cnt_q < LEN_WIDTH'(2 * ETH_MAC_LEN))
          src_sh_q <= {src_sh_q[39:0], din};
        if (cnt_q == LEN_WIDTH'(ETH_HDR_LEN - 2))
          type_hi_q <= din;
        if (cnt_q == LEN_WIDTH'(ETH_HDR_LEN - 1)) begin
          hdr_vld_q <= 1'b1;
          dest_q    <= da_q;
          src_q     <= src_sh_q;
          type_q    <= {type_hi_q, din};
        end
      end
    end
  end

  assign m_axis.tdata        = tdata_q;
  assign m_axis.tvalid       = tvalid_q;
  assign m_axis.tlast        = tlast_q;
  assign m_axis.tuser        = tuser_q;
  assign m_eth_hdr_valid     = hdr_vld_q;
  assign m_eth_dest_mac      = dest_q;
  assign m_eth_src_mac       = src_q;
  assign m_eth_type          = type_q;
  assign stat_frame_accepted = st_acc_q;
  assign stat_frame_dropped  = st_drop_q;
  assign stat_frame_runt     = st_runt_q;
  assign stat_frame_oversize = st_over_q;

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Bench for eth_rx_mac_filter: directed table, flush/reset corner sequences,
// and randomized frames checked against a rule-level reference model.
module tb_eth_rx_mac_filter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_rx_mac_filter_if #(.DATA_WIDTH(8)) s_if ();
  eth_rx_mac_filter_if #(.DATA_WIDTH(8)) m_if ();

  logic        hdr_v;
  logic [47:0] dmac, smac;
  logic [15:0] etype;
  logic [47:0] cfg_local_mac;
  logic        cfg_promisc, cfg_bcast_enable, cfg_mcast_enable;
  logic [15:0] cfg_max_len;
  logic        st_acc, st_drop, st_runt, st_over;

  eth_rx_mac_filter #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .s_axis              (s_if),
    .m_axis              (m_if),
    .m_eth_hdr_valid     (hdr_v),
    .m_eth_dest_mac      (dmac),
    .m_eth_src_mac       (smac),
    .m_eth_type          (etype),
    .cfg_local_mac       (cfg_local_mac),
    .cfg_promisc         (cfg_promisc),
    .cfg_bcast_enable    (cfg_bcast_enable),
    .cfg_mcast_enable    (cfg_mcast_enable),
    .cfg_max_len         (cfg_max_len),
    .stat_frame_accepted (st_acc),
    .stat_frame_dropped  (st_drop),
    .stat_frame_runt     (st_runt),
    .stat_frame_oversize (st_over)
  );

  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;
  localparam logic [47:0] SA    = 48'h0A_1B_2C_3D_4E_5F;
  localparam logic [15:0] ETYPE = 16'h0800;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- output monitor ----------------
  logic [7:0]  got_q[$];
  int          n_last, last_pos, n_acc, n_drop, n_runt, n_over, n_hdr;
  logic        last_user;
  logic [47:0] h_d, h_s;
  logic [15:0] h_t;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_if.tvalid) begin
        got_q.push_back(m_if.tdata);
        if (m_if.tlast) begin
          n_last++;
          last_pos  = got_q.size();
          last_user = m_if.tuser;
        end
      end
      if (st_acc)  n_acc++;
      if (st_drop) n_drop++;
      if (st_runt) n_runt++;
      if (st_over) n_over++;
      if (hdr_v) begin
        n_hdr++;
        h_d = dmac;
        h_s = smac;
        h_t = etype;
      end
    end
  end

  task automatic clear_mon();
    got_q = {};
    n_last = 0; last_pos = 0; n_acc = 0; n_drop = 0;
    n_runt = 0; n_over = 0; n_hdr = 0; last_user = 1'b0;
    h_d = '0; h_s = '0; h_t = '0;
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic build(input logic [47:0] da, input int len, output logic [7:0] f[$]);
    f = {};
    for (int i = 0; i < len; i++) begin
      if (i < 6)       f.push_back(da[47-8*i -: 8]);
      else if (i < 12) f.push_back(SA[47-8*(i-6) -: 8]);
      else if (i < 14) f.push_back(ETYPE[15-8*(i-12) -: 8]);
      else             f.push_back(8'($urandom));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] f[$], input int gap, input logic err);
    for (int i = 0; i < f.size(); i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = f[i];
      s_if.tlast  = (i == f.size() - 1);
      s_if.tuser  = (i == f.size() - 1) & err;
      @(posedge clk);
      #1;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
      idle(gap);
    end
  endtask

  task automatic verify(input string nm, input logic [7:0] f[$], input bit pass,
                        input bit tuser, input bit runt, input bit over, input int drop);
    int bad;
    int n;
    bit exp_hdr;
    bad = 0;
    exp_hdr = pass && (f.size() >= 14);
    check({nm, "_nbytes"}, got_q.size(), pass ? f.size() : 0);
    n = (got_q.size() < f.size()) ? got_q.size() : f.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== f[i]) bad++;
    check({nm, "_bytes"}, bad, 0);
    check({nm, "_ntlast"}, n_last, pass ? 1 : 0);
    if (pass) begin
      check({nm, "_tlastpos"}, last_pos, f.size());
      check({nm, "_tuser"}, last_user, tuser);
    end
    check({nm, "_acc"}, n_acc, pass ? 1 : 0);
    check({nm, "_drop"}, n_drop, drop);
    check({nm, "_runt"}, n_runt, runt);
    check({nm, "_over"}, n_over, over);
    check({nm, "_nhdr"}, n_hdr, exp_hdr ? 1 : 0);
    if (exp_hdr) begin
      check({nm, "_hdr_da"}, h_d, {f[0], f[1], f[2], f[3], f[4], f[5]});
      check({nm, "_hdr_sa"}, h_s, SA);
      check({nm, "_hdr_type"}, h_t, ETYPE);
    end
  endtask

  // Reference filter rule, straight from the station-address policy.
  function automatic bit model_accept(input logic [47:0] da, input bit pr, input bit bc, input bit mc);
    bit is_b;
    is_b = (da == BCAST);
    return pr || (da == LOCAL) || (is_b && bc) || (da[40] && !is_b && mc);
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [47:0] da;
    int          len;
    int          gap;
    bit          err, promisc, bcast, mcast;
    int          maxl;
    bit          pass, tuser, runt, over;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [7:0] f[$];
    logic [7:0] fb[$];

    tbl[0]  = '{LOCAL, 60,   0, 0, 0, 0, 0, 1514, 1, 0, 0, 0};
    tbl[1]  = '{OTHER, 60,   0, 0, 0, 0, 0, 1514, 0, 0, 0, 0};
    tbl[2]  = '{OTHER, 60,   0, 0, 1, 0, 0, 1514, 1, 0, 0, 0};
    tbl[3]  = '{BCAST, 60,   0, 0, 0, 0, 0, 1514, 0, 0, 0, 0};
    tbl[4]  = '{BCAST, 60,   0, 0, 0, 1, 0, 1514, 1, 0, 0, 0};
    tbl[5]  = '{MCAST, 60,   0, 0, 0, 0, 1, 1514, 1, 0, 0, 0};
    tbl[6]  = '{MCAST, 60,   0, 0, 0, 0, 0, 1514, 0, 0, 0, 0};
    tbl[7]  = '{LOCAL, 40,   0, 0, 0, 0, 0, 1514, 1, 1, 1, 0};
    tbl[8]  = '{LOCAL, 4,    0, 0, 0, 0, 0, 1514, 0, 0, 1, 0};
    tbl[9]  = '{LOCAL, 1515, 0, 0, 0, 0, 0, 1514, 1, 1, 0, 1};
    tbl[10] = '{LOCAL, 1514, 0, 0, 0, 0, 0, 1514, 1, 0, 0, 0};
    tbl[11] = '{LOCAL, 64,   1, 1, 0, 0, 0, 1514, 1, 1, 0, 0};
    tbl[12] = '{LOCAL, 13,   0, 0, 0, 0, 0, 1514, 1, 1, 1, 0};
    tbl[13] = '{LOCAL, 7,    2, 0, 0, 0, 0, 1514, 1, 1, 1, 0};
    tbl[14] = '{LOCAL, 6,    0, 0, 0, 0, 0, 1514, 0, 0, 1, 0};
    tbl[15] = '{BCAST, 80,   0, 0, 1, 0, 0, 1514, 1, 0, 0, 0};

    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    cfg_local_mac = LOCAL; cfg_promisc = 1'b0; cfg_bcast_enable = 1'b0;
    cfg_mcast_enable = 1'b0; cfg_max_len = 16'd1514;
    clear_mon();

    // Reset state.
    #12;
    check("rst_tvalid", m_if.tvalid, 0);
    check("rst_tlast", m_if.tlast, 0);
    check("rst_hdr", {hdr_v, dmac, smac, etype}, 0);
    check("rst_stats", {st_acc, st_drop, st_runt, st_over}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 16; i++) begin
      cfg_promisc      = tbl[i].promisc;
      cfg_bcast_enable = tbl[i].bcast;
      cfg_mcast_enable = tbl[i].mcast;
      cfg_max_len      = 16'(tbl[i].maxl);
      build(tbl[i].da, tbl[i].len, f);
      clear_mon();
      send(f, tbl[i].gap, tbl[i].err);
      idle(14);
      verify($sformatf("tbl%0d", i), f, tbl[i].pass, tbl[i].tuser,
             tbl[i].runt, tbl[i].over, tbl[i].pass ? 0 : 1);
    end

    // Frame starting during FLUSH, long enough to end in DROP.
    cfg_promisc = 1'b0; cfg_bcast_enable = 1'b0; cfg_mcast_enable = 1'b0;
    cfg_max_len = 16'd1514;
    build(LOCAL, 20, f);
    build(LOCAL, 10, fb);
    clear_mon();
    send(f, 0, 1'b0);
    send(fb, 0, 1'b0);
    idle(14);
    verify("flush_long", f, 1, 1, 1, 0, 1);

    // Frame starting and ending inside FLUSH.
    build(LOCAL, 3, fb);
    clear_mon();
    send(f, 0, 1'b0);
    send(fb, 0, 1'b0);
    idle(14);
    verify("flush_short", f, 1, 1, 1, 0, 1);

    // Asynchronous reset in the middle of PASS.
    build(LOCAL, 40, f);
    clear_mon();
    for (int i = 0; i < 12; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = f[i];
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    check("midrst_pre_tvalid", m_if.tvalid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", m_if.tvalid, 0);
    check("midrst_hdr_da", dmac, 0);
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    build(LOCAL, 60, f);
    clear_mon();
    send(f, 0, 1'b0);
    idle(14);
    verify("after_rst", f, 1, 0, 0, 0, 0);

    // Randomized frames against the rule model.
    for (int k = 0; k < 30; k++) begin
      logic [47:0] da;
      int len, gap, maxl, sel;
      bit err, pass;
      sel = $urandom_range(0, 4);
      case (sel)
        0: da = LOCAL;
        1: da = OTHER;
        2: da = BCAST;
        3: da = {8'h01, 8'($urandom), 32'($urandom)};
        default: da = {16'($urandom), 32'($urandom)};
      endcase
      len  = $urandom_range(1, 200);
      gap  = $urandom_range(0, 2);
      err  = 1'($urandom);
      sel  = $urandom_range(0, 2);
      maxl = (sel == 0) ? 100 : (sel == 1) ? 150 : 1514;
      cfg_promisc      = ($urandom_range(0, 3) == 0);
      cfg_bcast_enable = 1'($urandom);
      cfg_mcast_enable = 1'($urandom);
      cfg_max_len      = 16'(maxl);
      pass = (len > 6) && model_accept(da, cfg_promisc, cfg_bcast_enable, cfg_mcast_enable);
      build(da, len, f);
      clear_mon();
      send(f, gap, err);
      idle(14);
      verify($sformatf("rnd%0d", k), f, pass,
             err || (len < 60) || (len > maxl),
             pass ? (len < 60) : (len <= 6),
             pass && (len > maxl),
             pass ? 0 : 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eth_rx_mac_filter.md
Name: eth_rx_mac_filter

Overview:
- Sits directly downstream of the GMII/MII frame receiver. Consumes its AXI-Stream byte output: no tready, FCS already stripped, tuser=1 on tlast marks a bad frame.
- Parses the 14-byte Ethernet header and filters on destination MAC. Drops rejected frames whole; forwards accepted frames byte-exact.
- Flags runt and oversize frames on tuser and emits status pulses for the MAC statistics block.

Parameters:
- DATA_WIDTH, 8, stream width; any other value is an elaboration error.
- LEN_WIDTH, 16, width of the frame byte counter and cfg_max_len.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  8  input byte
- s_axis_tvalid  in  1  input beat valid; may be gapped (MII / clk_enable)
- s_axis_tlast  in  1  last byte of frame
- s_axis_tuser  in  1  bad-frame flag, meaningful only with tlast
- m_axis_tdata  out  8  output byte
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  output last
- m_axis_tuser  out  1  output bad-frame flag, on tlast
- m_eth_hdr_valid  out  1  one-cycle pulse: header fields updated
- m_eth_dest_mac  out  48  destination MAC, first byte received in [47:40]
- m_eth_src_mac  out  48  source MAC, same byte order
- m_eth_type  out  16  EtherType, first byte in [15:8]
- cfg_local_mac  in  48  station address, same byte order
- cfg_promisc  in  1  accept every DA
- cfg_bcast_enable  in  1  accept FF:FF:FF:FF:FF:FF
- cfg_mcast_enable  in  1  accept DA with bit 0 of the first byte set (I/G bit)
- cfg_max_len  in  LEN_WIDTH  maximum frame length in bytes, excluding FCS
- stat_frame_accepted  out  1  pulse per accepted frame, at output tlast
- stat_frame_dropped  out  1  pulse per dropped frame
- stat_frame_runt  out  1  pulse when the frame is under 60 bytes
- stat_frame_oversize  out  1  pulse when the frame exceeds cfg_max_len

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0, header fields 0, state IDLE, delay line and counter cleared. Reset mid-frame drops the partial frame with no tlast emitted. After release the block resumes in IDLE.
- Input is never back-pressured. At most one beat per cycle.
- Byte counter cnt counts valid beats of the current frame and saturates at all-ones.
- A 6-byte delay line holds the DA so the filter decision is made before any byte leaves the block.
- States:
  - IDLE: first valid beat loads delay line slot 0, cnt=1, go to DA.
  - DA: shift bytes in. On the 6th byte, evaluate the filter using cfg sampled on that cycle.
    - Accept if cfg_promisc, or DA==cfg_local_mac, or (DA==broadcast and cfg_bcast_enable), or (DA bit40 set and DA not broadcast and cfg_mcast_enable).
    - Accept -> PASS; reject -> DROP.
    - tlast at or before the 6th byte: frame dropped; stat_frame_dropped and stat_frame_runt pulse; -> IDLE.
  - PASS: each input beat shifts in; the oldest byte appears on m_axis one cycle later (tvalid=1, tlast=0). Bytes 7..14 load src MAC and type. m_eth_hdr_valid pulses the cycle after byte 14 arrives; fields hold until the next pulse. Input tlast -> FLUSH.
  - FLUSH: drains the 6 stored bytes on 6 consecutive cycles. tlast and tuser go on the final byte. m_axis_tuser = s_axis_tuser(last) | runt (cnt<60) | oversize (cnt>cfg_max_len). stat_frame_accepted, stat_frame_runt and stat_frame_oversize pulse with the final byte. -> IDLE.
  - DROP: discard beats until tlast; stat_frame_dropped pulses on that cycle; -> IDLE.
- A valid beat arriving during FLUSH starts a frame that is discarded whole: the block enters DROP after the flush and counts one drop.
- A frame shorter than 14 bytes in PASS produces no m_eth_hdr_valid; its bytes are still output.
- Latency in PASS: output byte n is valid one cycle after input byte n+6.

Decomposition:
- eth_pkg holds: ETH_MAC_LEN=6, ETH_HDR_LEN=14, ETH_MIN_LEN_NO_FCS=60, ETH_BCAST_MAC, and the state encoding (IDLE, DA, PASS, DROP, FLUSH).
- One sub-module, axis_byte_delay6: a 6-deep shift register with a shift-in-on-valid mode and a drain mode, and an empty output.

Test Plan:
- Unicast: cfg_local_mac=02:00:00:00:00:01, 60-byte frame to that DA, type 0x0800 -> 60 identical bytes out, tlast on byte 60, tuser=0, one hdr_valid with dest/src/type correct, stat_frame_accepted=1.
- Mismatch: DA=02:00:00:00:00:02 with promisc=0 -> no m_axis_tvalid, stat_frame_dropped=1. Same frame with promisc=1 -> passed.
- Broadcast / multicast: broadcast DA with bcast_enable=0 -> dropped, =1 -> passed. DA=01:00:5E:00:00:01 with mcast_enable=1 -> passed, =0 -> dropped.
- Length: 40-byte accepted frame -> 40 bytes out, tuser=1, stat_frame_runt. 4-byte frame -> nothing out, runt and dropped pulse. cfg_max_len=1514: 1515 bytes -> tuser=1 and oversize; 1514 bytes -> tuser=0.
- Error passthrough and gaps: valid every other cycle (MII), s_axis_tuser=1 on tlast -> output bytes unchanged, tuser=1 on last. Frame starting during FLUSH -> dropped, dropped count +1.
- Reset: rst_n low mid-PASS -> m_axis_tvalid=0 immediately. Next frame after release passes cleanly.
